// File: rtl/serial_frame_rx.sv
// -----------------------------------------------------------------------------
// serial_frame_rx
//
// Purpose:
//   Serial frame receiver. It samples one bit per rising clk edge from an
//   already-registered serial line. A frame is a start bit 0, then WIDTH
//   data bits sent LSB first, then an optional even-parity bit, then a stop
//   bit 1. A good frame updates dout and pulses valid for one cycle.
//   A stop bit sampled as 0 pulses frame_err, and the receiver then waits in
//   BREAK until the line returns high. A parity mismatch pulses parity_err.
//
// Configuration:
//   SERIAL_RX_PARITY_EN : when this macro is defined, the PARITY state is
//                         present and parity is checked. The received parity
//                         bit must equal the XOR of the data bits. When it is
//                         undefined, parity_err is tied to 0.
//
// Ports:
//   clk         in   1      rising-edge clock
//   rst         in   1      asynchronous active-high reset
//   din         in   1      serial line; idle level 1
//   dout        out  WIDTH  last correctly received word; holds between frames
//   valid       out  1      one-cycle strobe: dout just updated
//   frame_err   out  1      one-cycle strobe: stop bit sampled as 0
//   parity_err  out  1      one-cycle strobe: parity mismatch
//   busy        out  1      receiver is not in IDLE
// -----------------------------------------------------------------------------
module serial_frame_rx #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic             frame_err,
  output logic             parity_err,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DATA,
    S_STOP,
    S_BREAK
`ifdef SERIAL_RX_PARITY_EN
    , S_PARITY
`endif
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_shreg;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_dout;
  logic             r_valid;
  logic             r_frame_err;

`ifdef SERIAL_RX_PARITY_EN
  logic             r_par;
  logic             r_parity_err;
  logic             w_par_ok;

  // Even parity overall: the parity bit repeats the XOR of the data bits.
  assign w_par_ok   = ((^r_shreg) == r_par);
  assign parity_err = r_parity_err;
`else
  assign parity_err = 1'b0;
`endif

  // NOTE: every state register below is updated with <= so that all of them
  // sample the values from before the edge. A blocking = here would let a
  // later statement see an already-updated value and create an ordering race.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the shift register and the counter are reset as well. This is
      // not strictly needed for correct operation, but it keeps dout and the
      // internal state deterministic after reset, including after an abort
      // in the middle of a frame.
      r_state     <= S_IDLE;
      r_shreg     <= '0;
      r_cnt       <= '0;
      r_dout      <= '0;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
      r_par        <= 1'b0;
      r_parity_err <= 1'b0;
`endif
    end else begin
      // Strobes default low, so each one lasts exactly one cycle.
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
      r_parity_err <= 1'b0;
`endif
      unique case (r_state)
        S_IDLE: begin
          if (!din) begin
            r_state <= S_DATA;
            r_cnt   <= '0;
          end
        end

        S_DATA: begin
          // LSB arrives first, so bits enter at the top and shift down.
          r_shreg <= {din, r_shreg[WIDTH-1:1]};
          r_cnt   <= r_cnt + CW'(1);
          if (r_cnt == CW'(WIDTH - 1)) begin
`ifdef SERIAL_RX_PARITY_EN
            r_state <= S_PARITY;
`else
            r_state <= S_STOP;
`endif
          end
        end

`ifdef SERIAL_RX_PARITY_EN
        S_PARITY: begin
          r_par   <= din;
          r_state <= S_STOP;
        end
`endif

        S_STOP: begin
          if (din) begin
            r_state <= S_IDLE;
`ifdef SERIAL_RX_PARITY_EN
            if (w_par_ok) begin
              r_dout  <= r_shreg;
              r_valid <= 1'b1;
            end else begin
              r_parity_err <= 1'b1;
            end
`else
            r_dout  <= r_shreg;
            r_valid <= 1'b1;
`endif
          end else begin
            // A bad stop bit takes priority; parity is not evaluated.
            r_frame_err <= 1'b1;
            r_state     <= S_BREAK;
          end
        end

        S_BREAK: begin
          // While the line is held low, it is never taken as a new start bit.
          if (din) r_state <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign dout      = r_dout;
  assign valid     = r_valid;
  assign frame_err = r_frame_err;
  assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_serial_frame_rx.sv
// -----------------------------------------------------------------------------
// tb_serial_frame_rx
//
// Directed testbench for serial_frame_rx with WIDTH = 8. Inputs are driven
// 1 time unit after each rising edge, and outputs are checked at that same
// point. A passive monitor counts strobes on falling edges and records the
// cycles in which valid is high.
// Define SERIAL_RX_PARITY_EN to build the parity variant of the bench.
// -----------------------------------------------------------------------------
module tb_serial_frame_rx;

  localparam int WIDTH = 8;
`ifdef SERIAL_RX_PARITY_EN
  localparam int FRAME_LEN = WIDTH + 3;
`else
  localparam int FRAME_LEN = WIDTH + 2;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             din = 1'b1;
  logic [WIDTH-1:0] dout;
  logic             valid;
  logic             frame_err;
  logic             parity_err;
  logic             busy;

  int n_checks = 0;
  int n_pass   = 0;

  // Monitor state.
  int cyc      = 0;
  int n_valid  = 0;
  int n_ferr   = 0;
  int n_perr   = 0;
  int n_multi  = 0;
  int valid_cyc[$];

  serial_frame_rx #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .dout       (dout),
    .valid      (valid),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid === 1'b1) begin
      n_valid <= n_valid + 1;
      valid_cyc.push_back(cyc);
    end
    if (frame_err === 1'b1)  n_ferr <= n_ferr + 1;
    if (parity_err === 1'b1) n_perr <= n_perr + 1;
    if ((int'(valid === 1'b1) + int'(frame_err === 1'b1) + int'(parity_err === 1'b1)) > 1)
      n_multi <= n_multi + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Drive one bit, let the DUT sample it, and return 1 unit after the edge.
  task automatic send_bit(input logic b);
    din = b;
    @(posedge clk);
    #1;
  endtask

  task automatic send_data(input logic [WIDTH-1:0] data);
    for (int i = 0; i < WIDTH; i++) send_bit(data[i]);
  endtask

  // Complete frame. In the parity build, a correct parity bit is inserted.
  task automatic send_frame(input logic [WIDTH-1:0] data, input logic stop_bit);
    send_bit(1'b0);
    send_data(data);
`ifdef SERIAL_RX_PARITY_EN
    send_bit(^data);
`endif
    send_bit(stop_bit);
  endtask

  initial begin
    int v0, f0, p0;

    // ---------------- Reset asserted between edges ----------------
    #2 rst = 1'b1;
    #1;
    check("rst_dout",  32'(dout), 32'h0);
    check("rst_valid", 32'(valid), 32'h0);
    check("rst_ferr",  32'(frame_err), 32'h0);
    check("rst_perr",  32'(parity_err), 32'h0);
    check("rst_busy",  32'(busy), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 10; i++) send_bit(1'b1);
    check("idle_hold_outputs", 32'({dout, valid, frame_err, parity_err, busy}), 32'h0);

    // ---------------- Good frame 0xA5 ----------------
    v0 = n_valid;
    send_bit(1'b0);
    check("a5_busy_after_start", 32'(busy), 32'h1);
    send_data(8'hA5);
`ifdef SERIAL_RX_PARITY_EN
    send_bit(^8'hA5);
`endif
    check("a5_no_valid_before_stop", 32'(valid), 32'h0);
    send_bit(1'b1);
    check("a5_valid", 32'(valid), 32'h1);
    check("a5_dout", 32'(dout), 32'hA5);
    check("a5_busy_low", 32'(busy), 32'h0);
    send_bit(1'b1);
    check("a5_valid_one_cycle", 32'(valid), 32'h0);
    check("a5_valid_count", 32'(n_valid - v0), 32'd1);

    // ---------------- Framing error 0x3C, then held low ----------------
    v0 = n_valid;
    f0 = n_ferr;
    send_frame(8'h3C, 1'b0);
    check("ferr_strobe", 32'(frame_err), 32'h1);
    check("ferr_no_valid", 32'(valid), 32'h0);
    check("ferr_dout_kept", 32'(dout), 32'hA5);
    check("ferr_busy", 32'(busy), 32'h1);
    for (int i = 0; i < 5; i++) begin
      send_bit(1'b0);
      check("break_busy_high", 32'(busy), 32'h1);
    end
    send_bit(1'b1);
    check("break_exit_busy_low", 32'(busy), 32'h0);
    send_bit(1'b1);
    send_bit(1'b1);
    check("break_no_spurious_start", 32'(busy), 32'h0);
    check("ferr_count", 32'(n_ferr - f0), 32'd1);
    check("ferr_valid_count", 32'(n_valid - v0), 32'd0);
    check("ferr_dout_still", 32'(dout), 32'hA5);

    // ---------------- Back-to-back 0x3C, 0xC3 ----------------
    v0 = n_valid;
    send_frame(8'h3C, 1'b1);
    check("b2b_first_valid", 32'(valid), 32'h1);
    check("b2b_first_dout", 32'(dout), 32'h3C);
    send_frame(8'hC3, 1'b1);
    check("b2b_second_valid", 32'(valid), 32'h1);
    check("b2b_second_dout", 32'(dout), 32'hC3);
    send_bit(1'b1);
    check("b2b_valid_count", 32'(n_valid - v0), 32'd2);
    if (valid_cyc.size() >= 2)
      check("b2b_spacing", 32'(valid_cyc[valid_cyc.size()-1] - valid_cyc[valid_cyc.size()-2]),
            32'(FRAME_LEN));
    else
      check("b2b_spacing_missing_pulses", 32'(valid_cyc.size()), 32'd2);

    // ---------------- Reset in the middle of frame 0xFF ----------------
    v0 = n_valid;
    f0 = n_ferr;
    p0 = n_perr;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    rst = 1'b1;
    #1;
    check("midrst_dout", 32'(dout), 32'h0);
    check("midrst_busy", 32'(busy), 32'h0);
    #1 rst = 1'b0;
    send_bit(1'b1);
    send_bit(1'b1);
    check("midrst_no_strobes", 32'((n_valid - v0) + (n_ferr - f0) + (n_perr - p0)), 32'd0);
    send_frame(8'h12, 1'b1);
    check("after_rst_valid", 32'(valid), 32'h1);
    check("after_rst_dout", 32'(dout), 32'h12);
    send_bit(1'b1);

`ifdef SERIAL_RX_PARITY_EN
    // ---------------- Parity ----------------
    p0 = n_perr;
    send_bit(1'b0);
    send_data(8'h07);
    send_bit(1'b1);
    send_bit(1'b1);
    check("par_good_valid", 32'(valid), 32'h1);
    check("par_good_dout", 32'(dout), 32'h07);
    send_bit(1'b1);
    v0 = n_valid;
    send_bit(1'b0);
    send_data(8'h07);
    send_bit(1'b0);
    send_bit(1'b1);
    check("par_bad_perr", 32'(parity_err), 32'h1);
    check("par_bad_no_valid", 32'(valid), 32'h0);
    check("par_bad_dout_kept", 32'(dout), 32'h07);
    send_bit(1'b1);
    check("par_bad_perr_one_cycle", 32'(parity_err), 32'h0);
    check("par_perr_count", 32'(n_perr - p0), 32'd1);
    check("par_bad_valid_count", 32'(n_valid - v0), 32'd0);
`else
    check("perr_tied_low_count", 32'(n_perr), 32'd0);
`endif

    check("strobes_exclusive", 32'(n_multi), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
